// File: rtl/mult_booth.sv
// Signed 32x32 multiplier, radix-4 Booth, one digit per clock over 16 cycles.
// Also holds the carry-lookahead adder used for partial-product accumulation.

module cla #(
    parameter int WIDTH = 34
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] carry;

    // Carries inside each 4-bit group are expanded as sum-of-products from the
    // group's incoming carry; group carries chain from one group to the next.
    always_comb begin : carry_tree
        int   base;
        logic gacc;
        logic pacc;
        gen      = a & b;
        prop     = a ^ b;
        carry    = '0;
        carry[0] = cin;
        for (int i = 1; i < WIDTH; i++) begin
            base = ((i - 1) / 4) * 4;
            gacc = 1'b0;
            pacc = 1'b1;
            for (int j = i - 1; j >= base; j--) begin
                gacc = gacc | (pacc & gen[j]);
                pacc = pacc & prop[j];
            end
            carry[i] = gacc | (pacc & carry[base]);
        end
        sum = prop ^ carry;
    end

endmodule

module mult_booth (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        load;
    logic        step;
    logic        done;

    logic [31:0] mcand;
    logic [33:0] acc;
    logic [31:0] low;
    logic        guard;
    logic [3:0]  count;

    logic [33:0] addend;
    logic        carry_in;
    logic [33:0] sum;
    logic [33:0] acc_next;
    logic [31:0] low_next;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // A start request always wins, even on the cycle that would otherwise finish.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        done       = 1'b0;
        if (ctrl_MULT) begin
            load       = 1'b1;
            state_next = RUN;
        end else if (state == RUN) begin
            step = 1'b1;
            if (count == 4'd15) begin
                done       = 1'b1;
                state_next = IDLE;
            end
        end
    end

    // Negative multiples come from the inverted operand plus the adder's carry-in.
    always_comb begin
        addend   = '0;
        carry_in = 1'b0;
        case ({low[1:0], guard})
            3'b001, 3'b010: addend = {{2{mcand[31]}}, mcand};
            3'b011:         addend = {mcand[31], mcand, 1'b0};
            3'b100: begin
                addend   = ~{mcand[31], mcand, 1'b0};
                carry_in = 1'b1;
            end
            3'b101, 3'b110: begin
                addend   = ~{{2{mcand[31]}}, mcand};
                carry_in = 1'b1;
            end
            default: addend = '0;
        endcase
    end

    cla #(.WIDTH(34)) u_cla (
        .a   (acc),
        .b   (addend),
        .cin (carry_in),
        .sum (sum)
    );

    assign acc_next = {{2{sum[33]}}, sum[33:2]};
    assign low_next = {sum[1:0], low[31:2]};

    always_ff @(posedge clock) begin
        if (reset) begin
            mcand          <= '0;
            acc            <= '0;
            low            <= '0;
            guard          <= 1'b0;
            count          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= done;
            if (load) begin
                mcand <= data_operandA;
                acc   <= '0;
                low   <= data_operandB;
                guard <= 1'b0;
                count <= '0;
            end else if (step) begin
                acc   <= acc_next;
                low   <= low_next;
                guard <= low[1];
                count <= count + 4'd1;
            end
            // Upper product word must be a pure sign extension of the low word.
            if (done) begin
                data_result    <= low_next;
                data_exception <= (acc_next[31:0] != {32{low_next[31]}});
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_mult_booth.sv
// Self-checking bench for mult_booth: directed corner cases, aborts, resets,
// and a randomized back-to-back sweep against a plain 64-bit arithmetic model.

module tb_mult_booth;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int          assert_count = 0;
    int          fail_count   = 0;
    logic [31:0] last_result;
    logic        last_exception;
    int          strobes;

    mult_booth dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 64'(pa * pb);
    endfunction

    function automatic logic ref_overflow(input logic [63:0] p);
        longint full;
        longint trunc;
        full  = longint'(p);
        trunc = longint'($signed(p[31:0]));
        return full != trunc;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 9))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd0;
            4:       return 32'($urandom_range(0, 65535));
            5:       return -32'($urandom_range(0, 65535));
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Caller is in the low clock phase; the start is sampled on the next rising edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
    endtask

    // Called right after a start edge; leaves the bench in the strobe cycle's low phase.
    task automatic waitResult(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int          cycles;
        bit          seen;
        p = ref_product(a, b);
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        checkOutput("start_busy", 64'(busy), 64'd1);
        checkOutput("start_rdy", 64'(data_resultRDY), 64'd0);
        checkOutput("start_hold", 64'(data_result), 64'(last_result));
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 40) begin
            @(posedge clock);
            cycles++;
            @(negedge clock);
            if (data_resultRDY) seen = 1'b1;
            else checkOutput("run_hold", 64'(data_exception), 64'(last_exception));
        end
        checkOutput("latency", 64'(cycles), 64'd16);
        checkOutput("result", 64'(data_result), 64'(p[31:0]));
        checkOutput("exception", 64'(data_exception), 64'(ref_overflow(p)));
        checkOutput("done_busy", 64'(busy), 64'd0);
        last_result    = p[31:0];
        last_exception = ref_overflow(p);
    endtask

    task automatic countStrobes(input int n);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
            if (data_resultRDY) strobes++;
        end
    endtask

    initial begin
        reset          = 1'b1;
        ctrl_MULT      = 1'b0;
        data_operandA  = '0;
        data_operandB  = '0;
        last_result    = '0;
        last_exception = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_result", 64'(data_result), 64'd0);
        checkOutput("reset_exception", 64'(data_exception), 64'd0);
        checkOutput("reset_rdy", 64'(data_resultRDY), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        reset = 1'b0;

        // Basic signed case, then confirm the strobe lasts one cycle only.
        applyStimulus(32'd7, 32'hFFFF_FFFD);
        waitResult(32'd7, 32'hFFFF_FFFD);
        checkOutput("result_7x-3", 64'(data_result), 64'hFFFF_FFEB);
        @(posedge clock);
        @(negedge clock);
        checkOutput("rdy_one_cycle", 64'(data_resultRDY), 64'd0);

        applyStimulus(32'h8000_0000, 32'h8000_0000);
        waitResult(32'h8000_0000, 32'h8000_0000);
        applyStimulus(32'h8000_0000, 32'd1);
        waitResult(32'h8000_0000, 32'd1);
        applyStimulus(32'h0001_0000, 32'h0001_0000);
        waitResult(32'h0001_0000, 32'h0001_0000);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitResult(32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Restart eight edges into an operation.
        applyStimulus(32'd5, 32'd6);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (7) begin
            @(posedge clock);
            @(negedge clock);
            checkOutput("abort_rdy", 64'(data_resultRDY), 64'd0);
            checkOutput("abort_hold", 64'(data_result), 64'(last_result));
        end
        applyStimulus(32'd3, 32'd4);
        waitResult(32'd3, 32'd4);

        // Restart landing on the very edge that would have completed.
        applyStimulus(32'd100, 32'd200);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (15) begin
            @(posedge clock);
            @(negedge clock);
        end
        applyStimulus(32'hFFFF_FF00, 32'd77);
        waitResult(32'hFFFF_FF00, 32'd77);

        // Start held for three edges; only the last operands count.
        @(negedge clock);
        applyStimulus(32'd11, 32'd13);
        @(negedge clock);
        applyStimulus(32'd17, 32'd19);
        @(negedge clock);
        applyStimulus(32'h1234_5678, 32'hFEDC_BA98);
        waitResult(32'h1234_5678, 32'hFEDC_BA98);

        // Reset in the middle of an operation.
        @(negedge clock);
        applyStimulus(32'd9, 32'd9);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkOutput("midreset_result", 64'(data_result), 64'd0);
        checkOutput("midreset_exception", 64'(data_exception), 64'd0);
        checkOutput("midreset_rdy", 64'(data_resultRDY), 64'd0);
        checkOutput("midreset_busy", 64'(busy), 64'd0);
        strobes = 0;
        countStrobes(15);
        checkOutput("midreset_strobes", 64'(strobes), 64'd0);
        last_result    = '0;
        last_exception = 1'b0;
        applyStimulus(32'd9, 32'd9);
        waitResult(32'd9, 32'd9);
        checkOutput("result_81", 64'(data_result), 64'd81);

        // Reset and start on the same edge: nothing may launch.
        @(negedge clock);
        reset         = 1'b1;
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd3;
        @(posedge clock);
        @(negedge clock);
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        checkOutput("resetwins_busy", 64'(busy), 64'd0);
        strobes = 0;
        countStrobes(20);
        checkOutput("resetwins_strobes", 64'(strobes), 64'd0);
        last_result    = '0;
        last_exception = 1'b0;

        // Random sweep, each new start issued in the previous strobe cycle.
        for (int k = 0; k < 1000; k++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = pick_operand();
            b = pick_operand();
            applyStimulus(a, b);
            waitResult(a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/mult_booth.md
MULT_BOOTH -- requirements
Module: mult_booth

Interface
REQ-001 Parameters: none; operand width fixed at 32 bits.
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-004 ctrl_MULT  input  1  start pulse; a 1 sampled on an edge launches a multiply.
REQ-005 data_operandA  input  32  multiplicand, two's complement, sampled only on the start edge.
REQ-006 data_operandB  input  32  multiplier, two's complement, sampled only on the start edge.
REQ-007 data_result  output  32  low 32 bits of the signed 64-bit product A*B.
REQ-008 data_exception  output  1  1 when the signed product does not fit in 32 bits.
REQ-009 data_resultRDY  output  1  one-cycle completion strobe.
REQ-010 busy  output  1  1 while an operation is in progress.

Function
REQ-011 Algorithm: radix-4 Booth, 16 iterations; partial-product accumulation uses instances of the team's cla adder, sign-extended to 34 bits.
REQ-012 States: IDLE, RUN; 4-bit iteration counter; registered 66-bit product register {acc[33:0], B[31:0]} plus 1-bit Booth guard.
REQ-013 Start: edge N with ctrl_MULT=1 latches A as multiplicand M; loads acc=0, low half=B, guard=0, counter=0; state becomes RUN; busy=1 after edge N.
REQ-014 Each RUN edge: select op from {B-bits[1:0],guard}: 000/111 add 0; 001/010 +M; 011 +2M; 100 -2M; 101/110 -M; then arithmetic shift right by 2 across acc/low/guard; counter increments.
REQ-015 -M and -2M formed as inverted operand with cla carry-in=1; no separate subtractor.
REQ-016 Latency: the 16th RUN step occurs on edge N+16; after that edge data_result, data_exception valid, data_resultRDY=1 for exactly one cycle, busy=0, state IDLE.
REQ-017 data_exception = 1 iff the 64-bit product's bits [63:32] differ from 32 copies of bit 31.
REQ-018 data_result and data_exception hold their last completed value until the next completion or reset; they do not change during RUN.
REQ-019 ctrl_MULT=1 during RUN (including on edge N+16): abort current op, restart with newly sampled operands per REQ-013; aborted op never asserts data_resultRDY.
REQ-020 ctrl_MULT held high for multiple cycles: each sampled edge restarts; completion occurs 16 edges after the last sampled 1.
REQ-021 Operands changing after the start edge have no effect on the result.
REQ-022 No combinational path from any input to any output; all outputs are registered.

Reset
REQ-023 reset=1 on an edge: state IDLE, counter 0, product register 0, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
REQ-024 reset dominates ctrl_MULT on the same edge; no operation starts.
REQ-025 reset during RUN aborts the operation; no data_resultRDY is produced for it.

Verification
REQ-026 A=7, B=-3 (0xFFFFFFFD), pulse ctrl_MULT at edge N -> at N+16 data_result=0xFFFFFFEB, data_exception=0, data_resultRDY high exactly one cycle, busy low.
REQ-027 A=0x80000000, B=0x80000000 -> data_result=0x00000000, data_exception=1; A=0x80000000, B=1 -> data_result=0x80000000, data_exception=0.
REQ-028 A=0x00010000, B=0x00010000 -> data_result=0, data_exception=1; A=-1, B=-1 -> data_result=1, data_exception=0.
REQ-029 Start A=5,B=6; at edge N+8 pulse ctrl_MULT with A=3,B=4 -> no strobe at N+16; strobe at N+24 with data_result=12; data_result stays at its prior value until then.
REQ-030 Start A=9,B=9; assert reset at edge N+5 -> all outputs 0 after that edge, no strobe through N+20; a new start then completes normally with data_result=81.
REQ-031 Random sweep of 1000 signed operand pairs with back-to-back starts on the strobe cycle -> every data_result/data_exception matches the 64-bit reference product, one strobe per un-aborted start.
